// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the synchronous FIFO slice.
//   clog2    : ceiling log2, used for pointer and address widths
//   is_pow2  : true when a value is a power of two (value >= 1)
//   DEF_*    : default word width, depth and almost-full/empty levels
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_AF_LEVEL   = 6;
    localparam int DEF_AE_LEVEL   = 2;

    // Smallest r such that 2**r >= value; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// fifo_dp_ram
// DEPTH x DATA_WIDTH storage with one synchronous write port and one
// registered read port.
//   clk, rst_n : clock and async active-low reset (read register only)
//   wr_en      : write strobe; wr_data stored at wr_addr on the edge
//   rd_en      : read strobe; mem[rd_addr] captured into rd_data
//   rd_data    : registered read data, holds when rd_en is low
// The array itself is never reset. A read and write to the same address
// on one edge returns the old contents, which the FIFO relies on when it
// accepts a write into a full FIFO alongside a read of the oldest word.
module fifo_dp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: plain synchronous write, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: the output register clears on reset and otherwise holds
    // its last value until the next accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl
// Synchronous FIFO: storage, pointers, occupancy count and status flags.
//   clk, rst_n   : clock and asynchronous active-low reset
//   wr_en/data_in: write request and data
//   rd_en        : read request
//   data_out     : read data, one cycle after an accepted read; holds
//   data_valid   : data_out was updated by the previous edge
//   full/empty   : count == DEPTH / count == 0
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
//   count        : occupancy 0..DEPTH
//   overflow     : one-cycle pulse, a write was dropped
//   underflow    : one-cycle pulse, a read was dropped
// A write into a full FIFO is accepted when a read is accepted on the
// same edge. There is no fall-through: a word written into an empty FIFO
// can be read from the following edge onward.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_LEVEL   = DEF_AF_LEVEL,
    parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [clog2(DEPTH):0]    count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

    // Reject illegal parameter sets at elaboration rather than building
    // a FIFO whose flags or pointer wrap would be wrong.
    if (!(DEPTH >= 2 && is_pow2(DEPTH) && AE_LEVEL >= 0 &&
          AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_params
        $error("sync_fifo_ctrl: DEPTH must be a power of two >= 2 and 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic [CNT_W-1:0]  count_next;
    logic              rd_ok;
    logic              wr_ok;

    // Acceptance. The read side only looks at empty, so a write landing
    // in an empty FIFO can never be read on the same edge.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    // Next occupancy; a simultaneous read and write leaves it unchanged.
    always_comb begin
        count_next = count;
        if (wr_ok && !rd_ok) begin
            count_next = count + ONE;
        end else if (rd_ok && !wr_ok) begin
            count_next = count - ONE;
        end
    end

    // Pointers carry one extra wrap bit and simply roll over, so no
    // explicit wrap logic is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
            end
        end
    end

    // Count, flags and pulses are all registered from the next-state
    // count so they line up with count on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            data_valid   <= 1'b0;
        end else begin
            count        <= count_next;
            full         <= (count_next == DEPTH_CNT);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_CNT);
            almost_empty <= (count_next <= AE_CNT);
            overflow     <= wr_en && full && !rd_ok;
            underflow    <= rd_en && empty;
            data_valid   <= rd_ok;
        end
    end

    fifo_dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr[PTR_W-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr[PTR_W-1:0]),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl
// Self-checking bench for sync_fifo_ctrl at default parameters
// (32-bit words, depth 8, almost-full 6, almost-empty 2).
// Status outputs are compared against hand-written vector records;
// read data is compared against a scoreboard queue of accepted writes.
module tb_sync_fifo_ctrl;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] data_in;
    logic        rd_en;
    logic [31:0] data_out;
    logic        data_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int total;
    int bad;

    logic [31:0] sb[$];
    logic [31:0] last_data;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] din;
        logic [3:0]  cnt;
        logic        full;
        logic        empty;
        logic        af;
        logic        ae;
        logic        ovf;
        logic        unf;
        logic        valid;
    } vec_t;

    vec_t vecs[23];

    sync_fifo_ctrl #(
        .DATA_WIDTH (32),
        .DEPTH      (8),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic wr, input logic rd, input logic [31:0] din,
                                input logic [3:0] cnt, input logic f, input logic e,
                                input logic af, input logic ae, input logic ovf,
                                input logic unf, input logic valid);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt;
        v.full = f; v.empty = e; v.af = af; v.ae = ae;
        v.ovf = ovf; v.unf = unf; v.valid = valid;
        return v;
    endfunction

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        check1({tag, ".count"},        32'(count),        32'd0);
        check1({tag, ".empty"},        32'(empty),        32'd1);
        check1({tag, ".almost_empty"}, 32'(almost_empty), 32'd1);
        check1({tag, ".full"},         32'(full),         32'd0);
        check1({tag, ".almost_full"},  32'(almost_full),  32'd0);
        check1({tag, ".data_out"},     data_out,          32'd0);
        check1({tag, ".data_valid"},   32'(data_valid),   32'd0);
        check1({tag, ".overflow"},     32'(overflow),     32'd0);
        check1({tag, ".underflow"},    32'(underflow),    32'd0);
    endtask

    // Drive one cycle of stimulus; accepted writes go to the scoreboard.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        wr_en   = v.wr;
        rd_en   = v.rd;
        data_in = v.din;
        if (v.wr && !v.ovf) begin
            sb.push_back(v.din);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        logic [31:0] exp_data;
        check1({tag, ".count"},        32'(count),        32'(v.cnt));
        check1({tag, ".full"},         32'(full),         32'(v.full));
        check1({tag, ".empty"},        32'(empty),        32'(v.empty));
        check1({tag, ".almost_full"},  32'(almost_full),  32'(v.af));
        check1({tag, ".almost_empty"}, 32'(almost_empty), 32'(v.ae));
        check1({tag, ".overflow"},     32'(overflow),     32'(v.ovf));
        check1({tag, ".underflow"},    32'(underflow),    32'(v.unf));
        check1({tag, ".data_valid"},   32'(data_valid),   32'(v.valid));
        if (v.valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL %s.scoreboard actual=empty required=word", tag);
            end else begin
                exp_data = sb.pop_front();
                check1({tag, ".data_out"}, data_out, exp_data);
                last_data = exp_data;
            end
        end else begin
            check1({tag, ".data_hold"}, data_out, last_data);
        end
    endtask

    task automatic runVec(input vec_t v, input string tag);
        applyStimulus(v);
        checkOutput(v, tag);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        last_data = 32'd0;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        data_in   = 32'd0;

        //             wr rd din     cnt f  e  af ae ovf unf vld
        vecs[0]  = mk(1, 0, 32'h00, 1, 0, 0, 0, 1, 0, 0, 0);
        vecs[1]  = mk(1, 0, 32'h01, 2, 0, 0, 0, 1, 0, 0, 0);
        vecs[2]  = mk(1, 0, 32'h02, 3, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 32'h03, 4, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 32'h04, 5, 0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 0, 32'h05, 6, 0, 0, 1, 0, 0, 0, 0);
        vecs[6]  = mk(1, 0, 32'h06, 7, 0, 0, 1, 0, 0, 0, 0);
        vecs[7]  = mk(1, 0, 32'h07, 8, 1, 0, 1, 0, 0, 0, 0);
        vecs[8]  = mk(1, 0, 32'h08, 8, 1, 0, 1, 0, 1, 0, 0);
        vecs[9]  = mk(0, 0, 32'h00, 8, 1, 0, 1, 0, 0, 0, 0);
        vecs[10] = mk(1, 1, 32'hA5, 8, 1, 0, 1, 0, 0, 0, 1);
        vecs[11] = mk(0, 1, 32'h00, 7, 0, 0, 1, 0, 0, 0, 1);
        vecs[12] = mk(0, 1, 32'h00, 6, 0, 0, 1, 0, 0, 0, 1);
        vecs[13] = mk(0, 1, 32'h00, 5, 0, 0, 0, 0, 0, 0, 1);
        vecs[14] = mk(0, 1, 32'h00, 4, 0, 0, 0, 0, 0, 0, 1);
        vecs[15] = mk(0, 1, 32'h00, 3, 0, 0, 0, 0, 0, 0, 1);
        vecs[16] = mk(0, 1, 32'h00, 2, 0, 0, 0, 1, 0, 0, 1);
        vecs[17] = mk(0, 1, 32'h00, 1, 0, 0, 0, 1, 0, 0, 1);
        vecs[18] = mk(0, 1, 32'h00, 0, 0, 1, 0, 1, 0, 0, 1);
        vecs[19] = mk(0, 1, 32'h00, 0, 0, 1, 0, 1, 0, 1, 0);
        vecs[20] = mk(0, 0, 32'h00, 0, 0, 1, 0, 1, 0, 0, 0);
        vecs[21] = mk(1, 1, 32'h33, 1, 0, 0, 0, 1, 0, 1, 0);
        vecs[22] = mk(0, 1, 32'h00, 0, 0, 1, 0, 1, 0, 0, 1);

        #12;
        checkReset("por");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            runVec(vecs[i], $sformatf("vec%0d", i));
        end

        // Wrap: hold occupancy at 3 with 20 simultaneous write/read pairs.
        runVec(mk(1, 0, 32'h100, 1, 0, 0, 0, 1, 0, 0, 0), "wrap_fill0");
        runVec(mk(1, 0, 32'h101, 2, 0, 0, 0, 1, 0, 0, 0), "wrap_fill1");
        runVec(mk(1, 0, 32'h102, 3, 0, 0, 0, 0, 0, 0, 0), "wrap_fill2");
        for (int i = 0; i < 20; i++) begin
            runVec(mk(1, 1, 32'h200 + 32'(i), 3, 0, 0, 0, 0, 0, 0, 1),
                   $sformatf("wrap%0d", i));
        end
        runVec(mk(0, 1, 32'h0, 2, 0, 0, 0, 1, 0, 0, 1), "wrap_drain0");
        runVec(mk(0, 1, 32'h0, 1, 0, 0, 0, 1, 0, 0, 1), "wrap_drain1");
        runVec(mk(0, 1, 32'h0, 0, 0, 1, 0, 1, 0, 0, 1), "wrap_drain2");

        // Async reset in the middle of a burst, away from any clock edge.
        for (int i = 0; i < 5; i++) begin
            runVec(mk(1, 0, 32'h300 + 32'(i), 4'(i + 1), 0, 0, 0, (i < 2) ? 1'b1 : 1'b0, 0, 0, 0),
                   $sformatf("burst%0d", i));
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("async");
        sb.delete();
        last_data = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        runVec(mk(1, 0, 32'h5A, 1, 0, 0, 0, 1, 0, 0, 0), "post_wr");
        runVec(mk(0, 1, 32'h00, 0, 0, 1, 0, 1, 0, 0, 1), "post_rd");

        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
